// File: rtl/text_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : text_line_fetch
// Description : Double-buffered text line fetcher. It reads one whole text
//               row from port B of the line RAM into a back buffer, swaps
//               back and front buffers on request, and serves per-column
//               character words to the VGA renderer. The cursor overlay is
//               applied here by exchanging the FG and BG colour fields.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               line_req, line_row        - start a fetch of row line_row
//               line_swap                 - back buffer becomes front
//               frame_start               - once-per-frame pulse for blink
//               ram_address, ram_q        - RAM port B address / row data
//               char_col, char_data       - column in, word out (1-cycle)
//               front_row, front_valid    - front buffer status
//               back_ready, busy          - back buffer / fetch status
//               cursor_x/y, cursor_en     - cursor row, column, enable
//               blink_phase, err_sticky   - blink phase, sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module text_line_fetch #(
    parameter int                COLUMNS      = 80,
    parameter int                CHAR_W       = 32,
    parameter int                RAM_LAT      = 2,
    parameter int                FG_LSB       = 9,
    parameter int                BG_LSB       = 18,
    parameter int                COLOR_W      = 9,
    parameter int                BLINK_FRAMES = 30,
    parameter logic [CHAR_W-1:0] EMPTY_WORD   = 32'h0007fc20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_req,
    input  logic [7:0]              line_row,
    input  logic                    line_swap,
    input  logic                    frame_start,
    output logic [7:0]              ram_address,
    input  logic [COLUMNS*CHAR_W-1:0] ram_q,
    input  logic [7:0]              char_col,
    output logic [CHAR_W-1:0]       char_data,
    output logic [7:0]              front_row,
    output logic                    front_valid,
    output logic                    back_ready,
    output logic                    busy,
    input  logic [7:0]              cursor_x,
    input  logic [7:0]              cursor_y,
    input  logic                    cursor_en,
    output logic                    blink_phase,
    output logic [1:0]              err_sticky
);

    localparam int         c_ROW_BITS = COLUMNS * CHAR_W;
    localparam int         c_WAIT_W   = (RAM_LAT > 2) ? $clog2(RAM_LAT) : 1;
    localparam int         c_BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [8:0] c_COLUMNS  = 9'(COLUMNS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_WAIT_W-1:0]     r_wait_cnt;
    logic [7:0]              r_ram_address;
    logic [7:0]              r_fetch_row;
    logic [7:0]              r_back_row;
    logic [7:0]              r_front_row;
    logic                    r_front_valid;
    logic                    r_back_ready;
    logic                    r_sel;
    logic [c_BLINK_W-1:0]    r_blink_cnt;
    logic                    r_blink_phase;
    logic [1:0]              r_err;
    logic [CHAR_W-1:0]       r_char_data;
    logic [c_ROW_BITS-1:0]   r_buf0;
    logic [c_ROW_BITS-1:0]   r_buf1;

    logic                    w_busy;
    logic                    w_swap_ok;
    logic [c_ROW_BITS-1:0]   w_front;
    logic                    w_in_range;
    logic [7:0]              w_col_idx;
    logic [CHAR_W-1:0]       w_base;
    logic                    w_cursor_hit;
    logic [CHAR_W-1:0]       w_char_next;

    assign w_busy = (r_state != S_IDLE);
    // A swap during a fetch is refused: back_ready was cleared when the
    // fetch started, so the back buffer is never handed over half-written.
    assign w_swap_ok = line_swap && r_back_ready && !w_busy;

    // ------------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (line_req) w_state_next = S_ADDR;
            S_ADDR:  w_state_next = (RAM_LAT <= 1) ? S_LATCH : S_WAIT;
            // WAIT lasts RAM_LAT-1 cycles so ram_q is valid during LATCH.
            S_WAIT:  if (r_wait_cnt <= c_WAIT_W'(1)) w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Fetch bookkeeping, buffer swap, error flags, blink
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_ram_address <= '0;
            r_fetch_row   <= '0;
            r_back_row    <= '0;
            r_front_row   <= '0;
            r_front_valid <= 1'b0;
            r_back_ready  <= 1'b0;
            r_sel         <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_err         <= 2'b00;
        end else begin
            // Swap is evaluated first; a same-cycle fetch then targets the
            // buffer that was the front until this edge.
            if (w_swap_ok) begin
                r_sel         <= ~r_sel;
                r_front_row   <= r_back_row;
                r_front_valid <= 1'b1;
                r_back_ready  <= 1'b0;
            end else if (line_swap) begin
                r_err[1] <= 1'b1;
            end

            if (line_req) begin
                if (!w_busy) begin
                    r_ram_address <= line_row;
                    r_fetch_row   <= line_row;
                    r_back_ready  <= 1'b0;
                end else begin
                    r_err[0] <= 1'b1;
                end
            end

            case (r_state)
                S_ADDR:  r_wait_cnt <= c_WAIT_W'(RAM_LAT - 1);
                S_WAIT:  r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
                S_LATCH: begin
                    r_back_row   <= r_fetch_row;
                    r_back_ready <= 1'b1;
                end
                default: ;
            endcase

            if (frame_start) begin
                if (r_blink_cnt == c_BLINK_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
                end
            end
        end
    end

    // Line storage carries no reset: front_valid/back_ready gate its use.
    // r_sel=0 means buf0 is front, so the back buffer is the other one.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_LATCH) begin
            if (r_sel) begin
                r_buf0 <= ram_q;
            end else begin
                r_buf1 <= ram_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path with cursor overlay, one cycle latency
    // ------------------------------------------------------------------------
    assign w_front    = r_sel ? r_buf1 : r_buf0;
    assign w_in_range = ({1'b0, char_col} < c_COLUMNS);
    // Keep the part-select inside the row even for out-of-range columns.
    assign w_col_idx  = w_in_range ? char_col : 8'd0;

    always_comb begin
        w_base = EMPTY_WORD;
        if (w_in_range && r_front_valid) begin
            w_base = w_front[int'(w_col_idx) * CHAR_W +: CHAR_W];
        end
    end

    assign w_cursor_hit = cursor_en && r_blink_phase &&
                          (r_front_row == cursor_x) && (char_col == cursor_y);

    always_comb begin
        w_char_next = w_base;
        if (w_cursor_hit) begin
            w_char_next[FG_LSB +: COLOR_W] = w_base[BG_LSB +: COLOR_W];
            w_char_next[BG_LSB +: COLOR_W] = w_base[FG_LSB +: COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_data <= '0;
        end else begin
            r_char_data <= w_char_next;
        end
    end

    assign ram_address = r_ram_address;
    assign char_data   = r_char_data;
    assign front_row   = r_front_row;
    assign front_valid = r_front_valid;
    assign back_ready  = r_back_ready;
    assign busy        = w_busy;
    assign blink_phase = r_blink_phase;
    assign err_sticky  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_text_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_line_fetch
// Description : Directed self-checking bench for text_line_fetch. A small
//               RAM model with two cycles of read latency supplies rows;
//               expected words are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_line_fetch;

    localparam int c_COLS = 80;
    localparam int c_CW   = 32;
    localparam logic [31:0] c_EMPTY = 32'h0007fc20;

    logic                     clk;
    logic                     rst;
    logic                     line_req;
    logic [7:0]               line_row;
    logic                     line_swap;
    logic                     frame_start;
    logic [7:0]               ram_address;
    logic [c_COLS*c_CW-1:0]   ram_q;
    logic [7:0]               char_col;
    logic [31:0]              char_data;
    logic [7:0]               front_row;
    logic                     front_valid;
    logic                     back_ready;
    logic                     busy;
    logic [7:0]               cursor_x;
    logic [7:0]               cursor_y;
    logic                     cursor_en;
    logic                     blink_phase;
    logic [1:0]               err_sticky;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] mem [16][c_COLS];
    logic [7:0]  addr_d1;
    logic [7:0]  addr_d2;

    text_line_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .line_req    (line_req),
        .line_row    (line_row),
        .line_swap   (line_swap),
        .frame_start (frame_start),
        .ram_address (ram_address),
        .ram_q       (ram_q),
        .char_col    (char_col),
        .char_data   (char_data),
        .front_row   (front_row),
        .front_valid (front_valid),
        .back_ready  (back_ready),
        .busy        (busy),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_en   (cursor_en),
        .blink_phase (blink_phase),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B model: two register stages after the DUT's address register.
    always @(posedge clk) begin
        addr_d1 <= ram_address;
        addr_d2 <= addr_d1;
    end

    always_comb begin
        ram_q = '0;
        for (int c = 0; c < c_COLS; c++) begin
            ram_q[c*c_CW +: c_CW] = mem[addr_d2[3:0]][c];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_char_data"},   char_data,   32'h0);
        check({tag, "_ram_address"}, ram_address, 32'h0);
        check({tag, "_front_row"},   front_row,   32'h0);
        check({tag, "_front_valid"}, front_valid, 32'h0);
        check({tag, "_back_ready"},  back_ready,  32'h0);
        check({tag, "_busy"},        busy,        32'h0);
        check({tag, "_blink"},       blink_phase, 32'h0);
        check({tag, "_err"},         err_sticky,  32'h0);
    endtask

    initial begin
        // Pattern word = {row, col, 16'hBEEF}; row 3 col 0 overridden.
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < c_COLS; c++) begin
                mem[r][c] = {8'(r), 8'(c), 16'hBEEF};
            end
        end
        mem[3][0] = 32'h00abcd41;

        rst = 1'b1; line_req = 1'b0; line_row = 8'd0; line_swap = 1'b0;
        frame_start = 1'b0; char_col = 8'd0; cursor_x = 8'd0; cursor_y = 8'd0;
        cursor_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // 1. Invalid front gives the empty word.
        char_col = 8'd5;
        tick();
        check("empty_no_front", char_data, c_EMPTY);

        // 2. Fetch row 3, latency, swap, read.
        line_row = 8'd3; line_req = 1'b1;
        tick();
        line_req = 1'b0;
        check("busy_T1",        busy,        32'h1);
        check("ram_addr_3",     ram_address, 32'h3);
        tick(); tick();
        check("back_ready_T3",  back_ready,  32'h0);
        tick();
        check("back_ready_T4",  back_ready,  32'h1);
        check("busy_done",      busy,        32'h0);
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
        check("front_row_3",    front_row,   32'h3);
        check("front_valid",    front_valid, 32'h1);
        check("back_cleared",   back_ready,  32'h0);
        char_col = 8'd0;
        tick();
        check("r3c0",           char_data,   32'h00abcd41);
        char_col = 8'd1;
        tick();
        check("r3c1",           char_data,   32'h0301BEEF);

        // 3. Request dropped while busy; swap while busy refused.
        line_row = 8'd4; line_req = 1'b1;
        tick();
        line_row = 8'd7;
        tick();
        line_req = 1'b0;
        check("err_drop",       err_sticky,  32'h1);
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
        check("err_swap",       err_sticky,  32'h3);
        check("front_kept",     front_row,   32'h3);
        tick();
        check("row4_ready",     back_ready,  32'h1);
        check("row4_addr",      ram_address, 32'h4);

        // 4. Blink and cursor overlay on row 3 col 0.
        cursor_x = 8'd3; cursor_y = 8'd0; cursor_en = 1'b1; char_col = 8'd0;
        for (int i = 0; i < 29; i++) begin
            frame_start = 1'b1;
            tick();
        end
        frame_start = 1'b0;
        tick();
        check("blink_29",       blink_phase, 32'h0);
        check("cursor_off",     char_data,   32'h00abcd41);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("blink_30",       blink_phase, 32'h1);
        tick();
        check("cursor_on",      char_data,   32'h07985541);
        char_col = 8'd1;
        tick();
        check("cursor_col1",    char_data,   32'h0301BEEF);
        cursor_en = 1'b0;

        // 5. Out-of-range columns; simultaneous swap and request.
        char_col = 8'd80;
        tick();
        check("col80",          char_data,   c_EMPTY);
        char_col = 8'd255;
        tick();
        check("col255",         char_data,   c_EMPTY);
        line_swap = 1'b1; line_req = 1'b1; line_row = 8'd9;
        tick();
        line_swap = 1'b0; line_req = 1'b0;
        check("swap_first_row", front_row,   32'h4);
        check("swap_req_busy",  busy,        32'h1);
        char_col = 8'd1;
        tick();
        check("r4c1",           char_data,   32'h0401BEEF);
        tick(); tick();
        check("row9_ready",     back_ready,  32'h1);
        check("r4c1_kept",      char_data,   32'h0401BEEF);
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
        check("front_row_9",    front_row,   32'h9);
        char_col = 8'd2;
        tick();
        check("r9c2",           char_data,   32'h0902BEEF);

        // 6. Reset during WAIT aborts the fetch.
        line_row = 8'd5; line_req = 1'b1;
        tick();
        line_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midreset");
        tick(); tick(); tick();
        check("no_partial_rdy", back_ready,  32'h0);
        check("no_partial_bsy", busy,        32'h0);
        line_row = 8'd6; line_req = 1'b1;
        tick();
        line_req = 1'b0;
        tick(); tick(); tick();
        check("row6_ready",     back_ready,  32'h1);
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
        check("front_row_6",    front_row,   32'h6);
        char_col = 8'd3;
        tick();
        check("r6c3",           char_data,   32'h0603BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_line_fetch.md
Name: text_line_fetch

Overview:
- Downstream consumer of the text RAM that TextControl writes: owns the dual-port line RAM's read-only port B and double-buffers one text line at a time for the VGA character renderer.
- Serves per-column character words, with a cursor overlay and blink phase applied.
- Decouples renderer pixel timing from RAM read latency. Each line is fetched into a back buffer during the previous scanline group.

Parameters:
- COLUMNS, 80, characters per line (matches CONSOLE_COLUMNS).
- CHAR_W, 32, bits per character word (matches TEXT_RAM_CHAR_WIDTH).
- RAM_LAT, 2, port-B read latency in cycles, from address register to valid q.
- FG_LSB, 9, LSB of the foreground field in the char word.
- BG_LSB, 18, LSB of the background field.
- COLOR_W, 9, width of the fg and bg fields.
- BLINK_FRAMES, 30, frames per blink half-period.
- EMPTY_WORD, 32'h0007fc20, word returned for out-of-range columns.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- line_req  in  1  pulse: fetch row line_row into the back buffer.
- line_row  in  8  text row to fetch; sampled when line_req=1.
- line_swap  in  1  pulse: back buffer becomes front.
- frame_start  in  1  pulse once per frame; drives the blink counter.
- ram_address  out  8  port-B row address.
- ram_q  in  COLUMNS*CHAR_W  port-B read data.
- char_col  in  8  renderer column index.
- char_data  out  CHAR_W  word for char_col, with overlay applied.
- front_row  out  8  row held in the front buffer.
- front_valid  out  1  front buffer holds fetched data.
- back_ready  out  1  back-buffer fetch complete.
- busy  out  1  fetch in progress.
- cursor_x  in  8  cursor row.
- cursor_y  in  8  cursor column.
- cursor_en  in  1  cursor-visible mode.
- blink_phase  out  1  current blink phase.
- err_sticky  out  2  bit0 = line_req dropped while busy; bit1 = line_swap with back not ready.

Behaviour:
- Reset values:
  - char_data = 0, ram_address = 0, front_row = 0.
  - front_valid = 0, back_ready = 0, busy = 0.
  - blink_phase = 0, err_sticky = 0.
  - Blink counter = 0, FSM in IDLE, buffer select = 0.
  - Reset mid-fetch aborts the fetch; no partial latch occurs.
- FSM states IDLE, ADDR, WAIT, LATCH:
  - IDLE: on line_req, register line_row into ram_address and fetch_row, clear back_ready, set busy, go to ADDR.
  - ADDR: load wait counter = RAM_LAT-1, go to WAIT.
  - WAIT: decrement the counter; at 0 go to LATCH.
  - LATCH: capture ram_q into the back buffer, record back_row = fetch_row, set back_ready, clear busy, go to IDLE.
  - Fetch latency: line_req at cycle T gives back_ready=1 at T+RAM_LAT+2.
- line_req while busy: ignored, err_sticky[0] set, current fetch continues.
- line_swap:
  - If back_ready=1: toggle buffer select, front_row <= back_row, front_valid <= 1, back_ready <= 0.
  - If back_ready=0: no change, err_sticky[1] set.
- line_swap and line_req in the same cycle: the swap is applied first. The fetch then targets the new back buffer, i.e. the old front.
- line_swap while busy: treated as back_ready=0.
- Read path, 1-cycle latency (char_col sampled at T, char_data valid at T+1):
  - char_col >= COLUMNS, or front_valid=0: char_data = EMPTY_WORD.
  - Otherwise char_data = front[char_col*CHAR_W +: CHAR_W].
  - Column arithmetic is unsigned 8-bit; no wrap.
- Cursor overlay: if cursor_en and blink_phase=1 and front_row==cursor_x and the sampled char_col==cursor_y, the FG and BG fields of char_data are exchanged. All other bits pass through unchanged.
- Blink:
  - The counter increments on frame_start.
  - When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
  - frame_start coincident with any other event is processed independently.
- err_sticky clears only on reset.

Test Plan:
1. After reset, char_col=5 → char_data=32'h0007fc20; front_valid=0, busy=0, blink_phase=0.
2. RAM row 3 col 0 = 32'h00ab_cd41; line_req with line_row=3 at T → busy=1 at T+1, back_ready=1 at T+4. Then line_swap → front_row=3, front_valid=1; char_col=0 → char_data=32'h00abcd41 one cycle later.
3. line_req row 4 at T, second line_req row 7 at T+1 → row 4 fetched; err_sticky=2'b01. line_swap before back_ready → front unchanged, err_sticky=2'b11.
4. Front row 3, cursor_x=3, cursor_y=0, cursor_en=1:
   - 29 frame_start pulses → blink_phase=0, output unswapped.
   - 30th pulse → blink_phase=1, FG/BG fields of col 0 exchanged.
   - col 1 unaffected.
5. char_col=80 and char_col=255 with valid front → EMPTY_WORD. Simultaneous line_swap and line_req(row 9) → swap takes effect, then row 9 lands in the former front buffer; the next swap gives front_row=9.
6. Assert rst during WAIT → all outputs return to reset values next cycle; a subsequent line_req completes normally.
